// File: rtl/pc_seq_pkg.sv
// Shared types for the program-counter sequencer: FSM states, next-PC select
// encoding and the PC width.
package pc_seq_pkg;

  localparam int PC_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SEL_INC  = 2'd0,
    SEL_BRA  = 2'd1,
    SEL_CALL = 2'd2,
    SEL_RET  = 2'd3
  } pc_sel_e;

  // Sequential successor, modulo 2^16.
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] v);
    return v + 16'd1;
  endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// Hardware return-address LIFO. The top entry is held in a register so a pop
// can drive the PC directly, including right after a push.
module pc_ret_stack
  import pc_seq_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic [PC_W-1:0]         push_data,
  output logic [PC_W-1:0]         top,
  output logic [$clog2(DEPTH):0]  sp,
  output logic                    full,
  output logic                    empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = AW + 1;

  logic [PC_W-1:0] mem_q [DEPTH];
  logic [SW-1:0]   sp_q, sp_d;
  logic [PC_W-1:0] top_q, top_d;

  // Occupancy runs 0..DEPTH and wraps modulo DEPTH+1 when no guard stops it.
  function automatic logic [SW-1:0] sp_dec(input logic [SW-1:0] s);
    if (s == SW'(0)) begin
      return SW'(DEPTH);
    end else begin
      return s - SW'(1);
    end
  endfunction

  function automatic logic [SW-1:0] sp_inc(input logic [SW-1:0] s);
    if (s == SW'(DEPTH)) begin
      return SW'(0);
    end else begin
      return s + SW'(1);
    end
  endfunction

  // Storage slot for an occupancy value; DEPTH is a power of two.
  function automatic logic [AW-1:0] slot(input logic [SW-1:0] s);
    return s[AW-1:0];
  endfunction

  // Next occupancy and next top-of-stack; pop has priority over push.
  always_comb begin
    sp_d  = sp_q;
    top_d = top_q;
    if (pop) begin
      sp_d  = sp_dec(sp_q);
      top_d = mem_q[slot(sp_dec(sp_dec(sp_q)))];
    end else if (push) begin
      sp_d  = sp_inc(sp_q);
      top_d = push_data;
    end else begin
      sp_d  = sp_q;
      top_d = top_q;
    end
  end

  // Occupancy and top-of-stack registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q  <= SW'(0);
      top_q <= 16'h0000;
    end else begin
      sp_q  <= sp_d;
      top_q <= top_d;
    end
  end

  // Entry storage; contents are meaningless after reset.
  always_ff @(posedge clk) begin
    if (push && !pop) begin
      mem_q[slot(sp_q)] <= push_data;
    end
  end

  assign top   = top_q;
  assign sp    = sp_q;
  assign full  = (sp_q == SW'(DEPTH));
  assign empty = (sp_q == SW'(0));

endmodule

// File: rtl/pc_sequencer.sv
// PC sequencer: run/halt/fault FSM, next-PC priority select and PC register.
// Define PC_STACK_GUARD_EN to trap return-stack overflow/underflow into FAULT.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              STACK_DEPTH = 8,
  parameter logic [PC_W-1:0] RESET_VEC   = 16'h0000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         run,
  input  logic                         halt,
  input  logic                         stall,
  input  logic                         bra,
  input  logic [15:0]                  bra_addr,
  input  logic                         call,
  input  logic [15:0]                  call_addr,
  input  logic                         ret,
  output logic [15:0]                  pc,
  output logic                         pc_valid,
  output logic [$clog2(STACK_DEPTH):0] sp,
  output logic                         fault,
  output logic [1:0]                   state
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  pc_sel_e         sel;
  logic            push, pop;
  logic [PC_W-1:0] stk_top;
  logic            stk_full, stk_empty;

`ifdef PC_STACK_GUARD_EN
  logic fault_q, fault_d;
  logic stack_err;
  // ret checks underflow; call only matters when ret is absent.
  assign stack_err = (ret && stk_empty) || (!ret && call && stk_full);
`else
  logic stk_flags_unused;
  assign stk_flags_unused = stk_full | stk_empty;
`endif

  // Next state, next PC and stack controls.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    pop     = 1'b0;
`ifdef PC_STACK_GUARD_EN
    fault_d = fault_q;
`endif
    if (ret) begin
      sel = SEL_RET;
    end else if (call) begin
      sel = SEL_CALL;
    end else if (bra) begin
      sel = SEL_BRA;
    end else begin
      sel = SEL_INC;
    end

    case (state_q)
      IDLE, HALT: begin
        if (run && !stall) begin
          state_d = RUN;
        end else begin
          state_d = state_q;
        end
      end
      RUN: begin
        if (stall) begin
          state_d = state_q;
`ifdef PC_STACK_GUARD_EN
        end else if (stack_err) begin
          state_d = FAULT;
          fault_d = 1'b1;
`endif
        end else begin
          case (sel)
            SEL_RET: begin
              pc_d = stk_top;
              pop  = 1'b1;
            end
            SEL_CALL: begin
              pc_d = call_addr;
              push = 1'b1;
            end
            SEL_BRA: pc_d = bra_addr;
            default: pc_d = pc_inc(pc_q);
          endcase
          if (halt) begin
            state_d = HALT;
          end else begin
            state_d = RUN;
          end
        end
      end
      default: state_d = state_q;
    endcase
  end

  // State and PC registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_VEC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef PC_STACK_GUARD_EN
  // Sticky fault flag; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  pc_ret_stack #(
    .DEPTH(STACK_DEPTH)
  ) u_stack (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .push_data(pc_inc(pc_q)),
    .top      (stk_top),
    .sp       (sp),
    .full     (stk_full),
    .empty    (stk_empty)
  );

  assign pc       = pc_q;
  assign pc_valid = (state_q == RUN) && !stall;
  assign state    = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a spec-level model checked every cycle,
// plus hand-computed pins. Honours PC_STACK_GUARD_EN like the design.
module tb_pc_sequencer;

  localparam int D  = 8;
  localparam int SW = $clog2(D) + 1;
`ifdef PC_STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, run, halt, stall, bra, call, ret;
  logic [15:0]   bra_addr, call_addr;
  logic [15:0]   pc;
  logic          pc_valid;
  logic [SW-1:0] sp;
  logic          fault;
  logic [1:0]    state;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model of the architectural state.
  int m_pc, m_sp, m_state;
  int m_fault;
  int m_stk[D];

  pc_sequencer #(.STACK_DEPTH(D), .RESET_VEC(16'h0000)) dut (
    .clk(clk), .rst(rst), .run(run), .halt(halt), .stall(stall),
    .bra(bra), .bra_addr(bra_addr), .call(call), .call_addr(call_addr),
    .ret(ret), .pc(pc), .pc_valid(pc_valid), .sp(sp), .fault(fault),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the rising edge.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      chk("pc",       32'(pc),       m_pc);
      chk("pc_valid", 32'(pc_valid), 32'(m_state == 1 && !stall));
      chk("sp",       32'(sp),       m_sp);
      chk("fault",    32'(fault),    m_fault);
      chk("state",    32'(state),    m_state);
    end
  end

  // Apply one rising edge to the model using the current inputs.
  task automatic model_step();
    if (m_state == 1 && !stall) begin
      if (GUARD && ((ret && m_sp == 0) || (!ret && call && m_sp == D))) begin
        m_fault = 1;
        m_state = 3;
      end else begin
        if (ret) begin
          m_sp = (m_sp == 0) ? D : m_sp - 1;
          m_pc = m_stk[m_sp % D];
        end else if (call) begin
          m_stk[m_sp % D] = (m_pc + 1) % 65536;
          m_sp = (m_sp + 1) % (D + 1);
          m_pc = call_addr;
        end else if (bra) begin
          m_pc = bra_addr;
        end else begin
          m_pc = (m_pc + 1) % 65536;
        end
        if (halt) m_state = 2;
      end
    end else if (!stall && (m_state == 0 || m_state == 2) && run) begin
      m_state = 1;
    end
  endtask

  task automatic step(input bit r, input bit h, input bit s, input bit b,
                      input logic [15:0] ba, input bit c, input logic [15:0] ca,
                      input bit rt);
    run = r; halt = h; stall = s; bra = b; bra_addr = ba;
    call = c; call_addr = ca; ret = rt;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic nop();              step(0, 0, 0, 0, 16'h0, 0, 16'h0, 0); endtask
  task automatic go();               step(1, 0, 0, 0, 16'h0, 0, 16'h0, 0); endtask
  task automatic jump(input logic [15:0] a); step(0, 0, 0, 1, a, 0, 16'h0, 0); endtask
  task automatic sub(input logic [15:0] a);  step(0, 0, 0, 0, 16'h0, 1, a, 0); endtask
  task automatic rtn();              step(0, 0, 0, 0, 16'h0, 0, 16'h0, 1); endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    run = 0; halt = 0; stall = 0; bra = 0; call = 0; ret = 0;
    bra_addr = 16'h0; call_addr = 16'h0;
    rst = 1'b1;
    m_pc = 0; m_sp = 0; m_state = 0; m_fault = 0;
    #1;
    chk("rst_pc",       32'(pc),       32'h0000);
    chk("rst_sp",       32'(sp),       32'h0);
    chk("rst_state",    32'(state),    32'h0);
    chk("rst_fault",    32'(fault),    32'h0);
    chk("rst_pc_valid", 32'(pc_valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    do_reset();

    go();                         #1 chk("first_fetch_pc", 32'(pc), 32'h0000);
                                     chk("first_state", 32'(state), 32'h1);
    nop(); nop(); nop();          #1 chk("seq_pc", 32'(pc), 32'h0003);

    jump(16'h0010);
    sub(16'h0200);                #1 chk("call_sp", 32'(sp), 32'h1);
    nop();
    rtn();                        #1 chk("ret_pc", 32'(pc), 32'h0011);
                                     chk("ret_sp", 32'(sp), 32'h0);

    jump(16'h0043);
    sub(16'h0300);
    step(0, 0, 0, 1, 16'h0600, 1, 16'h0500, 1);
                                  #1 chk("ret_wins_pc", 32'(pc), 32'h0044);
                                     chk("ret_wins_sp", 32'(sp), 32'h0);

    jump(16'hFFFF);
    nop();                        #1 chk("wrap_pc", 32'(pc), 32'h0000);
    jump(16'hFFFF);
    sub(16'h0100);
    rtn();                        #1 chk("wrap_push", 32'(pc), 32'h0000);

    step(0, 0, 0, 1, 16'h0800, 1, 16'h0700, 0);
                                  #1 chk("call_over_bra", 32'(pc), 32'h0700);
    rtn();

    step(0, 1, 0, 1, 16'h1234, 0, 16'h0, 0);
                                  #1 chk("halt_bra_pc", 32'(pc), 32'h1234);
                                     chk("halt_state", 32'(state), 32'h2);
    nop();
    step(1, 0, 1, 0, 16'h0, 0, 16'h0, 0);
                                  #1 chk("halt_stall_run", 32'(state), 32'h2);
    go();
    nop();                        #1 chk("resume_pc", 32'(pc), 32'h1235);
    step(1, 1, 0, 0, 16'h0, 0, 16'h0, 0);
                                  #1 chk("halt_beats_run", 32'(state), 32'h2);
    go();

    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 16'h9999, 0, 16'h0, 0);
                                  #1 chk("stall_pc", 32'(pc), 32'h1236);
                                     chk("stall_valid", 32'(pc_valid), 32'h0);
    step(0, 1, 0, 0, 16'h0, 0, 16'h0, 0);
    go();                         #1 chk("stall_resume", 32'(pc), 32'h1237);
    nop();

    do_reset();
    go();
    nop();                        #1 chk("after_reset_pc", 32'(pc), 32'h0001);

    for (int i = 0; i < 9; i++) sub(16'h0A00 + 16'(i));
`ifdef PC_STACK_GUARD_EN
                                  #1 chk("ovf_fault", 32'(fault), 32'h1);
                                     chk("ovf_state", 32'(state), 32'h3);
                                     chk("ovf_sp",    32'(sp),    32'h8);
                                     chk("ovf_pc",    32'(pc),    32'h0A07);
    go();                         #1 chk("fault_sticky", 32'(state), 32'h3);
    do_reset();
    go();
    rtn();                        #1 chk("udf_fault", 32'(fault), 32'h1);
                                     chk("udf_pc", 32'(pc), 32'h0000);
`else
                                  #1 chk("wrap_sp", 32'(sp), 32'h0);
                                     chk("wrap_fault", 32'(fault), 32'h0);
    rtn();                        #1 chk("wrap_ret_pc", 32'(pc), 32'h0A08);
                                     chk("wrap_ret_sp", 32'(sp), 32'h8);
    rtn();                        #1 chk("wrap_ret2_pc", 32'(pc), 32'h0A07);
`endif
    nop();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the 16-bit core. It owns the PC register and a hardware return-address stack, and each cycle selects the next PC from sequential increment, branch target, call target or stack pop. It also runs a small run/halt/fault state machine that gates instruction fetch. It sits between the decode stage, which raises `bra`/`call`/`ret`, and the instruction memory address port.

## Interface
Parameters:
- `STACK_DEPTH`, default 8: return-stack entries; power of two, minimum 2.
- `RESET_VEC`, default 16'h0000: PC value loaded on reset.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `run` in 1: start or resume pulse; honoured in IDLE and HALT.
- `halt` in 1: stop request; honoured in RUN.
- `stall` in 1: freezes PC, stack and state for this cycle.
- `bra` in 1: branch taken.
- `bra_addr` in 16: branch target.
- `call` in 1: subroutine call.
- `call_addr` in 16: call target.
- `ret` in 1: return; pops the stack into the PC.
- `pc` out 16: current fetch address, registered.
- `pc_valid` out 1: `pc` is a fetch request; high only in RUN with `stall` low.
- `sp` out $clog2(STACK_DEPTH)+1: stack occupancy, 0..STACK_DEPTH.
- `fault` out 1: sticky stack-error flag.
- `state` out 2: current FSM state.

## Operation
- FSM states: IDLE=0, RUN=1, HALT=2, FAULT=3.
  - IDLE → RUN on `run`.
  - RUN → HALT on `halt`.
  - HALT → RUN on `run`.
  - Any state → FAULT on a stack error. Only reset leaves FAULT.
- PC updates occur only in RUN with `stall`=0. Priority is `ret` > `call` > `bra` > increment.
  - `ret`: `pc` ← top of stack; `sp` ← `sp`−1.
  - `call`: push `pc`+1; `sp` ← `sp`+1; `pc` ← `call_addr`.
  - `bra`: `pc` ← `bra_addr`.
  - None of the above: `pc` ← `pc`+1.
- Arithmetic: `pc`+1 is modulo 2^16, so 16'hFFFF wraps to 16'h0000. The pushed return address wraps the same way.
- Simultaneous controls:
  - `ret` with `call`: `ret` executes, `call` is dropped, no push.
  - `call` with `bra`: `call` wins.
  - `halt` with any control in RUN: the control executes that cycle, then the FSM enters HALT.
  - `run` and `halt` together in RUN: `halt` wins.
- Stalled or non-RUN cycles: `pc`, `sp`, stack contents and `state` all hold. Controls are ignored.
- Stack errors, with the guard compiled in:
  - `call` with `sp`=STACK_DEPTH is overflow.
  - `ret` with `sp`=0 is underflow.
  - On either error: no PC or stack change; `fault` ← 1; state ← FAULT.

## Timing
- Reset values: `pc`=RESET_VEC, `sp`=0, `fault`=0, `state`=IDLE, `pc_valid`=0. Stack contents are don't-care.
- Controls sampled at edge N take effect in `pc` after edge N (1-cycle latency). There is no combinational path from inputs to `pc`.
- `pc_valid` is combinational: (`state`==RUN) & ~`stall`.
- The first fetch is at the cycle after `run` is sampled in IDLE, with `pc`=RESET_VEC.
- Reset asserted mid-operation clears everything immediately (asynchronous). Operation resumes in IDLE after deassertion.
- A `call` in one cycle followed by a `ret` in the next cycle returns correctly (back-to-back push/pop).

## Configuration
- `PC_STACK_GUARD_EN` defined:
  - Overflow and underflow detection as described in Operation; FAULT is reachable.
- `PC_STACK_GUARD_EN` undefined:
  - No detection; `fault` is tied to 0 and FAULT is unreachable.
  - `sp` wraps modulo STACK_DEPTH+1 and the stack pointer indexes the stack modulo STACK_DEPTH.
  - Overflow overwrites the oldest entry.
  - Underflow returns the entry at the wrapped index.

## Structure
- Package `pc_seq_pkg`:
  - state enum (IDLE, RUN, HALT, FAULT);
  - `PC_W`=16;
  - next-PC select encoding (SEL_INC, SEL_BRA, SEL_CALL, SEL_RET).
- Sub-module `pc_ret_stack`: LIFO with push/pop/full/empty and a registered top-of-stack read.
- The top level holds the FSM, priority select and PC register.

## Test plan
- Reset, `run`, 4 idle cycles → `pc` sequence 0000, 0001, 0002, 0003; `pc_valid`=1; `sp`=0.
- At `pc`=0010, `call` to 0200; then at 0201, `ret` → `pc` 0200, 0201, 0011; `sp` goes 1 then 0.
- `ret` and `call` and `bra` together with `sp`=1 and top=0044 → `pc`=0044, `sp`=0, no push.
- `pc`=FFFF with no control → `pc`=0000. `call` at FFFF → pushes 0000.
- Guard on, 9 calls with STACK_DEPTH=8 → 9th call gives `fault`=1, `state`=FAULT, `pc` and `sp`=8 held. Guard off → `sp` wraps and `fault` stays 0.
- `stall` held 3 cycles during RUN with `bra` asserted → `pc` unchanged and `pc_valid`=0. `halt` then `run` → resumes at the held `pc`+1.
